run_length_sched: RTL and testbench

//   Sequencing controller for the board-level run-length recognizer (z=1 when w is stable >= RUN_LEN samples).

---
 rtl/run_length_sched.sv | 133 +++++++++++++
 tb/tb_run_length_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/run_length_sched.sv
// rtl/run_length_sched.sv - sample sequencing, run-length tracking and match counting for the run-length recognizer
// Optional auto-sample prescaler compiled in with RLC_AUTO_STEP_EN.
module run_length_sched #(
    parameter int RUN_LEN       = 4,
    parameter int CNT_W         = 4,
    parameter int MCNT_W        = 8,
    parameter int PRESCALE      = 50000000,
    parameter int HALT_ON_MATCH = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic              step,
    input  logic              w,
    output logic              sample_en,
    output logic              z,
    output logic [CNT_W-1:0]  run_len,
    output logic [MCNT_W-1:0] match_cnt,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  RL_MAX    = '1;
    localparam logic [MCNT_W-1:0] MC_MAX    = '1;
    localparam logic [CNT_W-1:0]  RUN_LEN_C = CNT_W'(RUN_LEN);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_run_len;
    logic [MCNT_W-1:0] r_match_cnt;
    logic              r_prev_w;
    logic              r_first;
    logic              r_z;
    logic              w_trig;
    logic              w_sample;
    logic [CNT_W-1:0]  w_new_len;
    logic              w_match;

`ifdef RLC_AUTO_STEP_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] r_presc;
    logic          w_tick;

    assign w_tick = (r_presc == PW'(PRESCALE - 1));
    assign w_trig = mode ? w_tick : step;

    // Free-runs only while sampling automatically; any other condition restarts it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (r_state == S_RUN && mode && !stop) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end else begin
            r_presc <= '0;
        end
    end
`else
    localparam int unused_prescale = PRESCALE;
    logic w_unused_mode;
    assign w_unused_mode = mode;
    assign w_trig        = step;
`endif

    assign w_sample = !rst && (r_state == S_RUN) && !stop && w_trig;

    always_comb begin
        w_new_len = 1'b1;
        if (!r_first && (w == r_prev_w)) begin
            w_new_len = (r_run_len == RL_MAX) ? RL_MAX : r_run_len + 1'b1;
        end
    end

    // A run that is already at RUN_LEN (including a saturated one) cannot match again
    assign w_match = (w_new_len == RUN_LEN_C) && (r_run_len != RUN_LEN_C);

    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_next = S_RUN;
                S_RUN:  if (w_sample && w_match && HALT_ON_MATCH != 0) w_next = S_HOLD;
                S_HOLD: if (start) w_next = S_RUN;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_len   <= '0;
            r_match_cnt <= '0;
            r_prev_w    <= 1'b0;
            r_first     <= 1'b0;
            r_z         <= 1'b0;
        end else if (stop) begin
            if (r_state != S_IDLE) r_z <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_run_len <= '0;
            r_z       <= 1'b0;
            r_first   <= 1'b1;
        end else if (w_sample) begin
            r_run_len <= w_new_len;
            r_prev_w  <= w;
            r_first   <= 1'b0;
            r_z       <= (w_new_len >= RUN_LEN_C);
            if (w_match && r_match_cnt != MC_MAX) r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    assign sample_en = w_sample;
    assign z         = r_z;
    assign run_len   = r_run_len;
    assign match_cnt = r_match_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_run_length_sched.sv
// tb/tb_run_length_sched.sv - scoreboard bench for run_length_sched, free-running and halt-on-match instances
module tb_run_length_sched;

    localparam int RL  = 4;
    localparam int CW  = 4;
    localparam int MW  = 3;
    localparam int PS  = 4;
    localparam int RLMAX = (1 << CW) - 1;
    localparam int MCMAX = (1 << MW) - 1;

    typedef struct {
        int se;
        int z;
        int rl;
        int mc;
        int st;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, stop, mode, step, w;
    logic          se0, z0, se1, z1;
    logic [CW-1:0] rl0, rl1;
    logic [MW-1:0] mc0, mc1;
    logic [1:0]    st0, st1;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t q0[$];
    exp_t q1[$];

    int m_st[2], m_rl[2], m_pw[2], m_first[2], m_z[2], m_mc[2], m_presc[2];

    always #5 clk = ~clk;

    run_length_sched #(.RUN_LEN(RL), .CNT_W(CW), .MCNT_W(MW), .PRESCALE(PS), .HALT_ON_MATCH(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .step(step), .w(w),
        .sample_en(se0), .z(z0), .run_len(rl0), .match_cnt(mc0), .state(st0));

    run_length_sched #(.RUN_LEN(RL), .CNT_W(CW), .MCNT_W(MW), .PRESCALE(PS), .HALT_ON_MATCH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .step(step), .w(w),
        .sample_en(se1), .z(z1), .run_len(rl1), .match_cnt(mc1), .state(st1));

    task automatic cmp(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    endtask

    // Reference: states 0=idle 1=run 2=hold, lengths as plain integers clipped to their maxima
    task automatic model_cycle(input int h, input bit r, input bit s, input bit p,
                               input bit m, input bit stp, input bit wv, output exp_t e);
        int trig, sampled, nl;
`ifdef RLC_AUTO_STEP_EN
        trig = m ? int'(m_presc[h] == PS - 1) : int'(stp);
`else
        trig = int'(stp);
`endif
        sampled = (!r && m_st[h] == 1 && !p && trig != 0) ? 1 : 0;
        e.se = sampled; e.z = m_z[h]; e.rl = m_rl[h]; e.mc = m_mc[h]; e.st = m_st[h];
        if (r) begin
            m_st[h] = 0; m_rl[h] = 0; m_pw[h] = 0; m_first[h] = 0; m_z[h] = 0; m_mc[h] = 0; m_presc[h] = 0;
        end else if (p) begin
            if (m_st[h] != 0) begin m_st[h] = 0; m_z[h] = 0; end
            m_presc[h] = 0;
        end else if (s && m_st[h] == 0) begin
            m_st[h] = 1; m_rl[h] = 0; m_z[h] = 0; m_first[h] = 1; m_presc[h] = 0;
        end else if (s && m_st[h] == 2) begin
            m_st[h] = 1; m_presc[h] = 0;
        end else if (m_st[h] == 1) begin
`ifdef RLC_AUTO_STEP_EN
            if (m) m_presc[h] = (m_presc[h] + 1) % PS;
            else   m_presc[h] = 0;
`endif
            if (sampled != 0) begin
                if (m_first[h] != 0 || int'(wv) != m_pw[h]) nl = 1;
                else nl = (m_rl[h] + 1 > RLMAX) ? RLMAX : m_rl[h] + 1;
                if (nl == RL && m_rl[h] != RL) begin
                    if (m_mc[h] < MCMAX) m_mc[h] = m_mc[h] + 1;
                    if (h == 1) m_st[h] = 2;
                end
                m_z[h] = (nl >= RL) ? 1 : 0;
                m_rl[h] = nl;
                m_pw[h] = int'(wv);
                m_first[h] = 0;
            end
        end else begin
            m_presc[h] = 0;
        end
    endtask

    // Called at posedge+1: apply inputs, predict this cycle's outputs, advance the model
    task automatic cyc(input bit r, input bit s, input bit p, input bit m, input bit stp, input bit wv);
        exp_t e0, e1;
        rst = r; start = s; stop = p; mode = m; step = stp; w = wv;
        model_cycle(0, r, s, p, m, stp, wv, e0);
        model_cycle(1, r, s, p, m, stp, wv, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_step(input bit wv);
        cyc(0, 0, 0, 0, 1, wv);
        cyc(0, 0, 0, 0, 0, wv);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("d0.sample_en", int'(se0), e.se);
            cmp("d0.z", int'(z0), e.z);
            cmp("d0.run_len", int'(rl0), e.rl);
            cmp("d0.match_cnt", int'(mc0), e.mc);
            cmp("d0.state", int'(st0), e.st);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("d1.sample_en", int'(se1), e.se);
            cmp("d1.z", int'(z1), e.z);
            cmp("d1.run_len", int'(rl1), e.rl);
            cmp("d1.match_cnt", int'(mc1), e.mc);
            cmp("d1.state", int'(st1), e.st);
        end
    end

    initial begin
        bit cur_mode, cur_w;
        rst = 1; start = 0; stop = 0; mode = 0; step = 0; w = 0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_rl[i] = 0; m_pw[i] = 0; m_first[i] = 0; m_z[i] = 0; m_mc[i] = 0; m_presc[i] = 0;
        end
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cmp("reset.state", int'(st0), 0);
        cmp("reset.run_len", int'(rl0), 0);

        // four equal samples: match on the fourth
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_step(1);
        cmp("t1.run_len", int'(rl0), 4);
        cmp("t1.z", int'(z0), 1);
        cmp("t1.match_cnt", int'(mc0), 1);
        cmp("t4.hold", int'(st1), 2);

        // halted instance ignores steps until resumed, then continues the run
        do_step(1);
        do_step(1);
        cmp("t4.frozen", int'(rl1), 4);
        cyc(0, 1, 0, 0, 0, 1);
        do_step(1);
        cmp("t4.resume_len", int'(rl1), 5);
        cmp("t4.no_rematch", int'(mc1), 1);

        // start and stop together: stop wins, run length held
        cyc(0, 1, 1, 0, 0, 1);
        cmp("t5.state", int'(st1), 0);
        cmp("t5.z", int'(z1), 0);
        cmp("t5.held", int'(rl1), 5);
        cyc(0, 1, 0, 0, 0, 1);
        cmp("t5.fresh", int'(rl0), 0);

        // break in the run restarts the count
        do_step(1); do_step(1); do_step(1);
        do_step(0); do_step(0); do_step(0);
        cmp("t2.mid_len", int'(rl0), 3);
        cmp("t2.mid_z", int'(z0), 0);
        do_step(0);
        cmp("t2.len", int'(rl0), 4);
        cmp("t2.match_cnt", int'(mc0), 2);

        // auto sampling (or steps only when the prescaler is compiled out)
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 24; i++) cyc(0, 0, 0, 1, 0, 1);
`ifdef RLC_AUTO_STEP_EN
        cmp("t3.auto_z", int'(z0), 1);
`else
        cmp("t3.mode_ignored", int'(rl0), 0);
`endif

        // reset from HOLD
        cyc(1, 0, 0, 0, 0, 0);
        cmp("t6.state", int'(st1), 0);
        cmp("t6.match_cnt", int'(mc1), 0);
        cmp("t6.z", int'(z1), 0);

        cur_mode = 0;
        cur_w = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) cur_mode = ~cur_mode;
            if ($urandom_range(0, 5) == 0) cur_w = ~cur_w;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                cur_mode, $urandom_range(0, 2) == 0, cur_w);
        end
        cyc(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        cmp("scoreboard.drained", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
